// File: rtl/ahb_apb_bridge_if.sv
// Purpose : bundles the AHB-Lite slave side and APB3 master side of the AHB->APB bridge.
// Latency : n/a (wires only).
// Backpressure: the AHB data phase is stalled by hreadyout; the APB access is stretched by pready.
// Ports   : hsel/haddr/htrans/hwrite/hsize/hwdata/hreadyin from the AHB master; hrdata/hreadyout/hresp back to it;
//           paddr/pwrite/psel/penable/pwdata to the APB slave; prdata/pready/pslverr back from it.
//           Modport slave = the bridge's view, modport master = the surrounding system's view.
interface ahb_apb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hreadyin;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyout;
  logic [1:0]            hresp;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hreadyin,
    output hrdata, hreadyout, hresp,
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready, pslverr
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hreadyin,
    input  hrdata, hreadyout, hresp,
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ahb_apb_bridge.sv
// Purpose : AHB-Lite slave to APB3 master bridge, one APB SETUP/ACCESS per AHB transfer, optional hang timeout.
// Latency : read data phase 2 cycles min (SETUP, ACCESS), write 3 (WDATA, SETUP, ACCESS), +1 per pready-low cycle.
// Backpressure: hreadyout held low until the APB access completes; slave errors/timeouts give a 2-cycle ERROR.
// Ports   : hclk (single clock), hreset (async active-high), bus (ahb_apb_bridge_if.slave: AHB + APB signals).
module ahb_apb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  ahb_apb_bridge_if.slave   bus
);

  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t                r_state;
  logic                  r_hready;
  logic                  r_err;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [CW-1:0]         r_tcnt;

  logic   w_capture;
  logic   w_done;
  logic   w_open;
  logic   w_timeout;
  state_t w_cap_state;
  logic   w_unused;

  assign w_unused    = bus.htrans[0];
  assign w_capture   = bus.hsel & bus.htrans[1] & bus.hreadyin;
  // Successful APB completion: the only cycle besides IDLE/ERR2 where a new address phase is accepted.
  assign w_done      = (r_state == S_ACCESS) & bus.pready & ~bus.pslverr;
  assign w_open      = (r_state == S_IDLE) | (r_state == S_ERR2) | w_done;
  // Oversized transfers are refused without touching the APB bus.
  assign w_cap_state = (bus.hsize > 3'b010) ? S_ERR1 : (bus.hwrite ? S_WDATA : S_SETUP);
  assign w_timeout   = (TIMEOUT != 0) && (r_tcnt == CW'(TLIM));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state   <= S_IDLE;
      r_hready  <= 1'b1;
      r_err     <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_tcnt    <= '0;
    end else if (w_open) begin
      r_penable <= 1'b0;
      if (w_capture) begin
        r_paddr  <= bus.haddr;
        r_pwrite <= bus.hwrite;
        r_state  <= w_cap_state;
        r_hready <= 1'b0;
        r_err    <= (w_cap_state == S_ERR1);
        // A read goes straight to SETUP, so psel is raised without a gap.
        r_psel   <= (w_cap_state == S_SETUP);
      end else begin
        r_state  <= S_IDLE;
        r_hready <= 1'b1;
        r_err    <= 1'b0;
        r_psel   <= 1'b0;
      end
    end else begin
      case (r_state)
        S_WDATA: begin
          r_pwdata <= bus.hwdata;
          r_state  <= S_SETUP;
          r_psel   <= 1'b1;
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
          r_tcnt    <= '0;
        end
        S_ACCESS: begin
          // Not w_done here, so pready high means pslverr high.
          if (bus.pready | w_timeout) begin
            r_state   <= S_ERR1;
            r_err     <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_hready  <= 1'b1;
          r_err     <= 1'b0;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  // Completion must release the AHB bus in the same cycle pready arrives, hence the combinational term.
  assign bus.hreadyout = r_hready | w_done;
  assign bus.hresp     = {1'b0, r_err};
  assign bus.hrdata    = (w_done & ~r_pwrite) ? bus.prdata : '0;
  assign bus.paddr     = r_paddr;
  assign bus.pwrite    = r_pwrite;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwdata    = r_pwdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Purpose : self-checking bench for ahb_apb_bridge (TIMEOUT=4): vector table, APB scoreboard, corner sequences.
// Latency : n/a.
// Backpressure: the APB slave model inserts a per-transfer number of pready-low ACCESS cycles.
module tb_ahb_apb_bridge;

  logic hclk;
  logic hreset;

  ahb_apb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // APB slave model: pready rises after cfg_wait ACCESS cycles
  int          cfg_wait  = 0;
  logic        cfg_err   = 1'b0;
  logic [31:0] cfg_rdata = '0;
  int          acc_cnt;

  always @(posedge hclk or posedge hreset) begin
    if (hreset) acc_cnt <= 0;
    else if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign bus.pready  = bus.psel & bus.penable & (acc_cnt >= cfg_wait);
  assign bus.pslverr = bus.pready & cfg_err;
  assign bus.prdata  = bus.pready ? cfg_rdata : 32'h0;

  // Scoreboard of expected APB accesses
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } sb_t;
  sb_t sb_q[$];

  int pen_cnt  = 0;
  int psel_cnt = 0;

  always @(negedge hclk) begin
    if (!hreset) begin
      if (bus.psel) psel_cnt++;
      if (bus.psel && bus.penable) pen_cnt++;
      if (bus.psel && bus.penable && bus.pready) begin
        if (sb_q.size() == 0) begin
          chk("apb_unexpected_access", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("apb_paddr", bus.paddr, e.addr);
          chk("apb_pwrite", {31'd0, bus.pwrite}, {31'd0, e.wr});
          if (e.wr) chk("apb_pwdata", bus.pwdata, e.wdata);
        end
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    logic        push;
    int          exp_low;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_pen;
    int          exp_psel;
  } vec_t;

  vec_t vecs[8];

  task automatic do_xfer(input vec_t v);
    int   low;
    logic done;
    logic [1:0] prev_resp;
    logic [1:0] resp;
    logic [31:0] rd;
    cfg_wait  = v.waits;
    cfg_err   = v.err;
    cfg_rdata = v.rdata;
    if (v.push) sb_q.push_back('{v.addr, v.wr, v.wdata});
    @(posedge hclk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = v.addr;
    bus.hwrite = v.wr; bus.hsize = v.size;
    @(posedge hclk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = v.wdata;
    pen_cnt = 0; psel_cnt = 0;
    low = 0; done = 1'b0; prev_resp = 2'b11; resp = 2'b11; rd = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge hclk); #1;
      if (bus.hreadyout) begin
        done = 1'b1; resp = bus.hresp; rd = bus.hrdata;
      end else begin
        low++; prev_resp = bus.hresp;
      end
    end
    if (!done) chk("xfer_completion_timeout", 32'd0, 32'd1);
    chk("wait_cycles", low, v.exp_low);
    chk("last_wait_hresp", {30'd0, prev_resp}, {30'd0, v.exp_resp});
    chk("final_hresp", {30'd0, resp}, {30'd0, v.exp_resp});
    chk("final_hrdata", rd, v.exp_rdata);
    chk("penable_cycles", pen_cnt, v.exp_pen);
    chk("psel_cycles", psel_cnt, v.exp_psel);
    // Following IDLE cycle must be a zero-wait OKAY
    @(negedge hclk); #1;
    chk("idle_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    chk("idle_hresp", {30'd0, bus.hresp}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    //          wr    addr          size    wdata         wt  err   rdata         push low resp   exp_rdata    pen psel
    vecs[0] = '{1'b0, 32'h4000_0010, 3'b010, 32'h0,        0,  1'b0, 32'hDEAD_BEEF, 1'b1, 1, 2'b00, 32'hDEAD_BEEF, 1, 2};
    vecs[1] = '{1'b1, 32'h4000_0020, 3'b010, 32'h1234_5678, 2,  1'b0, 32'h0,        1'b1, 4, 2'b00, 32'h0,        3, 4};
    vecs[2] = '{1'b0, 32'h4000_0030, 3'b010, 32'h0,        0,  1'b1, 32'h7777_7777, 1'b1, 3, 2'b01, 32'h0,        1, 2};
    vecs[3] = '{1'b1, 32'h4000_0044, 3'b001, 32'hA5A5_5A5A, 1,  1'b0, 32'h0,        1'b1, 3, 2'b00, 32'h0,        2, 3};
    vecs[4] = '{1'b0, 32'h4000_0048, 3'b010, 32'h0,        100, 1'b0, 32'h0,        1'b0, 6, 2'b01, 32'h0,        4, 5};
    vecs[5] = '{1'b1, 32'h4000_004C, 3'b011, 32'h0BAD_0BAD, 0,  1'b0, 32'h0,        1'b0, 1, 2'b01, 32'h0,        0, 0};
    vecs[6] = '{1'b0, 32'h4000_0050, 3'b000, 32'h0,        3,  1'b0, 32'h0BAD_F00D, 1'b1, 4, 2'b00, 32'h0BAD_F00D, 4, 5};
    vecs[7] = '{1'b1, 32'h4000_0054, 3'b010, 32'hFEED_0001, 1,  1'b1, 32'h0,        1'b1, 5, 2'b01, 32'h0,        2, 3};

    hreset = 1'b1;
    bus.hsel = 1'b0; bus.haddr = '0; bus.htrans = 2'b00; bus.hwrite = 1'b0;
    bus.hsize = 3'b010; bus.hwdata = '0; bus.hreadyin = 1'b1;
    repeat (2) @(posedge hclk);
    @(negedge hclk); #1;
    chk("rst_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    chk("rst_hresp", {30'd0, bus.hresp}, 32'd0);
    chk("rst_hrdata", bus.hrdata, 32'd0);
    chk("rst_psel", {31'd0, bus.psel}, 32'd0);
    chk("rst_penable", {31'd0, bus.penable}, 32'd0);
    chk("rst_pwrite", {31'd0, bus.pwrite}, 32'd0);
    chk("rst_paddr", bus.paddr, 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    for (int i = 0; i < 8; i++) do_xfer(vecs[i]);

    // Back-to-back: write 0x10 then read 0x14 presented in the write completion cycle
    cfg_wait = 0; cfg_err = 1'b0; cfg_rdata = 32'h5555_AAAA;
    sb_q.push_back('{32'h10, 1'b1, 32'hCAFE_0001});
    sb_q.push_back('{32'h14, 1'b0, 32'h0});
    @(posedge hclk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h10; bus.hwrite = 1'b1; bus.hsize = 3'b010;
    @(posedge hclk); #1;                 // WDATA
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = 32'hCAFE_0001;
    @(posedge hclk); #1;                 // SETUP
    @(posedge hclk); #1;                 // ACCESS, completes with pready high
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h14; bus.hwrite = 1'b0;
    @(negedge hclk); #1;
    chk("b2b_wr_done_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    @(posedge hclk); #1;                 // read SETUP
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    @(negedge hclk); #1;
    chk("b2b_setup_psel", {31'd0, bus.psel}, 32'd1);
    chk("b2b_setup_penable", {31'd0, bus.penable}, 32'd0);
    chk("b2b_setup_paddr", bus.paddr, 32'h14);
    chk("b2b_setup_pwrite", {31'd0, bus.pwrite}, 32'd0);
    @(negedge hclk); #1;                 // read ACCESS
    chk("b2b_rd_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    chk("b2b_rd_hrdata", bus.hrdata, 32'h5555_AAAA);
    @(negedge hclk); #1;

    // Reset in the middle of a hanging ACCESS
    cfg_wait = 100; cfg_err = 1'b0;
    @(posedge hclk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h4000_0060; bus.hwrite = 1'b0; bus.hsize = 3'b010;
    @(posedge hclk); #1;                 // SETUP
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    @(negedge hclk); #1;
    @(negedge hclk); #1;                 // ACCESS
    chk("mid_access_penable", {31'd0, bus.penable}, 32'd1);
    hreset = 1'b1;
    #1;
    chk("arst_psel", {31'd0, bus.psel}, 32'd0);
    chk("arst_penable", {31'd0, bus.penable}, 32'd0);
    chk("arst_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    @(posedge hclk); #1;
    hreset = 1'b0;
    rv = '{1'b0, 32'h4000_0064, 3'b010, 32'h0, 1, 1'b0, 32'h1357_9BDF, 1'b1, 2, 2'b00, 32'h1357_9BDF, 2, 3};
    do_xfer(rv);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
